// File: rtl/mem_access_unit_if.sv
// Pipeline-side request/response and data-memory port of the load/store unit.
// req is a strobe sampled only while busy=0; once taken, the unit ignores req/op/addr/wdata/pc until it returns to idle, and done pulses exactly one cycle with rdata/addr_err valid.
interface mem_access_unit_if;
  logic        req;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] pc;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        addr_err;
  logic [31:0] dm_addr;
  logic [31:0] dm_wd;
  logic        dm_we;
  logic [31:0] dm_pc;
  logic [31:0] dm_rdata;

  modport master (
    output req, op, addr, wdata, pc, dm_rdata,
    input  busy, done, rdata, addr_err, dm_addr, dm_wd, dm_we, dm_pc
  );

  modport slave (
    input  req, op, addr, wdata, pc, dm_rdata,
    output busy, done, rdata, addr_err, dm_addr, dm_wd, dm_we, dm_pc
  );
endinterface

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store unit: sub-word loads with extension, sub-word stores by
// read-modify-write, alignment/range checking that suppresses the memory access.
module mem_access_unit #(
  parameter int DM_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  mem_access_unit_if.slave  bus,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WRITE, S_DONE} state_e;
  typedef enum logic [2:0] {
    OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB
  } op_e;

  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DM_WORDS);

  state_e      state;
  op_e         op_r;
  logic [1:0]  lane_r;
  logic [15:0] wdata_r;
  logic [31:0] rdata_r;
  logic        addr_err_r;
  logic [31:0] dm_addr_r;
  logic [31:0] dm_wd_r;
  logic        dm_we_r;
  logic [31:0] dm_pc_r;

  op_e         req_op;
  logic        addr_bad;
  logic [15:0] rd_half;
  logic [7:0]  rd_byte;
  logic [31:0] load_val;
  logic [31:0] merged;

  assign req_op = op_e'(bus.op);

  always_comb begin
    addr_bad = (bus.addr >= ADDR_LIMIT);
    case (req_op)
      OP_LW, OP_SW:         if (bus.addr[1:0] != 2'b00) addr_bad = 1'b1;
      OP_LH, OP_LHU, OP_SH: if (bus.addr[0]) addr_bad = 1'b1;
      default:              ;
    endcase
  end

  // Lane selection from the word currently presented by memory.
  always_comb begin
    rd_half = lane_r[1] ? bus.dm_rdata[31:16] : bus.dm_rdata[15:0];
    case (lane_r)
      2'd0:    rd_byte = bus.dm_rdata[7:0];
      2'd1:    rd_byte = bus.dm_rdata[15:8];
      2'd2:    rd_byte = bus.dm_rdata[23:16];
      default: rd_byte = bus.dm_rdata[31:24];
    endcase
    case (op_r)
      OP_LH:   load_val = {{16{rd_half[15]}}, rd_half};
      OP_LHU:  load_val = {16'h0000, rd_half};
      OP_LB:   load_val = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  load_val = {24'h000000, rd_byte};
      default: load_val = bus.dm_rdata;
    endcase
  end

  always_comb begin
    merged = bus.dm_rdata;
    if (op_r == OP_SH) begin
      if (lane_r[1]) merged[31:16] = wdata_r;
      else           merged[15:0]  = wdata_r;
    end else begin
      case (lane_r)
        2'd0:    merged[7:0]   = wdata_r[7:0];
        2'd1:    merged[15:8]  = wdata_r[7:0];
        2'd2:    merged[23:16] = wdata_r[7:0];
        default: merged[31:24] = wdata_r[7:0];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      op_r       <= OP_LW;
      lane_r     <= 2'b00;
      wdata_r    <= 16'h0000;
      rdata_r    <= 32'h0;
      addr_err_r <= 1'b0;
      dm_addr_r  <= 32'h0;
      dm_wd_r    <= 32'h0;
      dm_we_r    <= 1'b0;
      dm_pc_r    <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          dm_we_r <= 1'b0;
          if (bus.req) begin
            op_r    <= req_op;
            lane_r  <= bus.addr[1:0];
            wdata_r <= bus.wdata[15:0];
            dm_pc_r <= bus.pc;
            if (addr_bad) begin
              addr_err_r <= 1'b1;
              state      <= S_DONE;
            end else begin
              addr_err_r <= 1'b0;
              dm_addr_r  <= {bus.addr[31:2], 2'b00};
              // A full-word store needs no read, so it writes during ACCESS.
              if (req_op == OP_SW) begin
                dm_we_r <= 1'b1;
                dm_wd_r <= bus.wdata;
              end
              state <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          case (op_r)
            OP_SW: begin
              dm_we_r <= 1'b0;
              state   <= S_DONE;
            end
            OP_SH, OP_SB: begin
              dm_wd_r <= merged;
              dm_we_r <= 1'b1;
              state   <= S_WRITE;
            end
            default: begin
              rdata_r <= load_val;
              state   <= S_DONE;
            end
          endcase
        end
        S_WRITE: begin
          dm_we_r <= 1'b0;
          state   <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = (state != S_IDLE);
  assign bus.done     = (state == S_DONE);
  assign bus.rdata    = rdata_r;
  assign bus.addr_err = addr_err_r;
  assign bus.dm_addr  = dm_addr_r;
  assign bus.dm_wd    = dm_wd_r;
  // Reset must block a write already registered for the current cycle.
  assign bus.dm_we    = dm_we_r & ~reset;
  assign bus.dm_pc    = dm_pc_r;
  assign state_dbg    = state;

endmodule
